// File: rtl/rob_alloc.sv
// rob_alloc: in-order ROB slot allocator, the upstream companion to the ROB.
//   Grants one slot index per cycle to decode (same-cycle, combinational),
//   mirrors the ROB head pointer, tracks occupancy and flags a retire that
//   arrives while nothing is in flight.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   clear           synchronous flush, shared with the ROB
//   allocReq        decode wants a slot this cycle
//   allocGrant      slot granted this cycle
//   allocIdx        granted slot index (current tail)
//   stall           allocReq without grant; decode holds its instruction
//   retire          ROB committed its head this cycle
//   headIdx         oldest in-flight slot
//   count           occupied slots
//   full, empty     count == ROB_SLOTS / count == 0
//   retireErr       sticky, set by retire while empty; cleared by rst only
module rob_alloc #(
  parameter int ROB_SLOTS    = 16,
  parameter int ROB_IDX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    allocReq,
  output logic                    allocGrant,
  output logic [ROB_IDX_BITS-1:0] allocIdx,
  output logic                    stall,
  input  logic                    retire,
  output logic [ROB_IDX_BITS-1:0] headIdx,
  output logic [ROB_IDX_BITS:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    retireErr
);

  localparam logic [ROB_IDX_BITS-1:0] LAST_IDX = ROB_IDX_BITS'(ROB_SLOTS - 1);
  localparam logic [ROB_IDX_BITS:0]   SLOTS_C  = (ROB_IDX_BITS+1)'(ROB_SLOTS);

  logic [ROB_IDX_BITS-1:0] tail, head;
  logic [ROB_IDX_BITS:0]   cnt;
  logic                    err;
  logic                    retire_ok;

  assign full  = (cnt == SLOTS_C);
  assign empty = (cnt == '0);

  // Retire never feeds the grant: a full ROB frees its slot for allocation
  // only on the cycle after the retire, keeping retire off this path.
  assign allocGrant = allocReq && !full && !clear && !rst;
  assign stall      = allocReq && !allocGrant;
  assign allocIdx   = tail;
  assign headIdx    = head;
  assign count      = cnt;
  assign retireErr  = err;

  assign retire_ok = retire && !empty;

  // Explicit wrap compare so non-power-of-two slot counts work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail <= '0;
      head <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else if (clear) begin
      // Flush restarts both pointers; the error flag survives on purpose.
      tail <= '0;
      head <= '0;
      cnt  <= '0;
    end else begin
      if (allocGrant) tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
      if (retire_ok)  head <= (head == LAST_IDX) ? '0 : head + 1'b1;
      if (retire && empty) err <= 1'b1;
      unique case ({allocGrant, retire_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
